// File: rtl/iter_muldiv.sv
// iter_muldiv: radix-2 sequential signed/unsigned multiply/divide returning {hi, lo}.
module iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [2:0] {IDLE, CALC, FIX, DONE, HOLD} state_t;
    state_t state, state_nx;
    logic [1:0] op_r;
    logic dz, neg_lo, neg_hi;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] mb;
    logic [2*WIDTH-1:0] acc;
    logic sa, sb, dz_in, ge;
    logic [WIDTH-1:0] abs_a, abs_b, dif, q, r, hi_fix, lo_fix;
    logic [WIDTH:0] msum, shl;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    always_comb begin
        sa = op[0] & a[WIDTH-1];
        sb = op[0] & b[WIDTH-1];
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
        dz_in = op[1] && b == '0;
        // mul adds into the upper half then shifts right; div shifts left into a WIDTH+1 bit partial remainder
        msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mb : {WIDTH{1'b0}}};
        shl = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        ge = shl >= {1'b0, mb};
        dif = shl[WIDTH-1:0] - mb;
        acc_step = op_r[1] ? {ge ? dif : shl[WIDTH-1:0], acc[WIDTH-2:0], ge}
                           : {msum, acc[WIDTH-1:1]};
        prod_fix = neg_lo ? -acc : acc;
        q = acc[WIDTH-1:0];
        r = acc[2*WIDTH-1:WIDTH];
        hi_fix = dz ? acc[WIDTH-1:0] : op_r[1] ? (neg_hi ? -r : r) : prod_fix[2*WIDTH-1:WIDTH];
        lo_fix = dz ? {WIDTH{1'b1}} : op_r[1] ? (neg_lo ? -q : q) : prod_fix[WIDTH-1:0];
        busy = state == CALC || state == FIX || state == DONE;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = dz_in ? FIX : CALC;
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX: state_nx = DONE;
            DONE: state_nx = start ? HOLD : IDLE;
            HOLD: if (!start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r <= '0;
            dz <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            cnt <= '0;
            mb <= '0;
            acc <= '0;
            done <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            done <= state == FIX;
            if (state == IDLE && start) begin
                op_r <= op;
                mb <= abs_b;
                acc <= {{WIDTH{1'b0}}, dz_in ? a : abs_a};
                dz <= dz_in;
                neg_lo <= sa ^ sb;
                neg_hi <= op[1] & sa;
                cnt <= '0;
            end
            if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + CNT_W'(1);
            end
            if (state == FIX) begin
                hi <= hi_fix;
                lo <= lo_fix;
            end
        end
    end
endmodule

// File: tb/tb_iter_muldiv.sv
// tb_iter_muldiv: vector table, random ops against an arithmetic model, and handshake/reset sequences.
module tb_iter_muldiv;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [1:0] op = '0;
    logic [31:0] a = '0, b = '0;
    logic busy, done;
    logic [31:0] hi, lo;
    int errors = 0, checks = 0;

    iter_muldiv dut (.clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
                     .busy(busy), .done(done), .hi(hi), .lo(lo));

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (o == 2'd0) return {32'h0, x} * {32'h0, y};
        if (o == 2'd1) return 64'(sx * sy);
        if (y == 0) return {x, 32'hFFFFFFFF};
        if (o == 2'd2) return {x % y, x / y};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int n, el;
        el = (o[1] && y == 0) ? 1 : 33;
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        chk({nm, " busy_at_accept"}, 64'(busy), 64'(1));
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 100);
        chk({nm, " latency"}, 64'(n), 64'(el));
        chk({nm, " hi"}, 64'(hi), 64'(ehi));
        chk({nm, " lo"}, 64'(lo), 64'(elo));
        @(posedge clk); #1;
        chk({nm, " done_one_cycle"}, 64'(done), 64'(0));
        chk({nm, " busy_after"}, 64'(busy), 64'(0));
    endtask

    initial begin
        logic [63:0] m;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        int pulses;
        vecs[0] = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{2'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        vecs[3] = '{2'd2, 32'd100, 32'd7, 32'd2, 32'd14};
        vecs[4] = '{2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5] = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000};
        vecs[6] = '{2'd2, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
        vecs[7] = '{2'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[8] = '{2'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};

        #12;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset hi", 64'(hi), 64'(0));
        chk("reset lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom);
            ra = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            rb = ($urandom_range(0, 6) == 0) ? 32'h0 : ($urandom_range(0, 5) == 0) ? 32'hFFFFFFFF : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            m = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), ro, ra, rb, m[63:32], m[31:0]);
        end

        @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("held done_pulses", 64'(pulses), 64'(1));
        chk("held busy", 64'(busy), 64'(0));
        chk("held hi", 64'(hi), 64'(0));
        chk("held lo", 64'(lo), 64'(12));
        @(negedge clk);
        start = 1'b0;
        run_op("after_hold divu", 2'd2, 32'd9, 32'd4, 32'd1, 32'd2);

        @(negedge clk);
        op = 2'd2; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst hi", 64'(hi), 64'(0));
        chk("midrst lo", 64'(lo), 64'(0));
        chk("midrst done", 64'(done), 64'(0));
        chk("midrst busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_reset multu", 2'd0, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
